// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcodes,
// ALUop codes and datapath mux selects. ALUcontrol imports the same ALUop codes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_R_WB,
    ST_EXEC_I,
    ST_I_WB,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP
  } state_e;

  localparam int OP_RTYPE = 0;
  localparam int OP_ADDI  = 1;
  localparam int OP_ANDI  = 2;
  localparam int OP_ORI   = 3;
  localparam int OP_SLTI  = 4;
  localparam int OP_LW    = 5;
  localparam int OP_SW    = 6;
  localparam int OP_BEQ   = 7;
  localparam int OP_J     = 8;

  localparam logic [2:0] ALU_FUNC = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // States that hold a memory request open and may stall on mem_ready.
  function automatic logic is_mem_wait(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_imm_alu_op_dec.sv
// Immediate-class opcode to ALUop mapping; purely combinational so a
// single-cycle datapath can reuse it unchanged.
module multicycle_ctrl_imm_alu_op_dec
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output logic [2:0]     alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OPW'(OP_ANDI)) begin
      alu_op = ALU_AND;
    end else if (opcode == OPW'(OP_ORI)) begin
      alu_op = ALU_OR;
    end else if (opcode == OPW'(OP_SLTI)) begin
      alu_op = ALU_SLT;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle datapath. Outputs decode from the state
// register; fetch/write enables are additionally gated by mem_ready and zero.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPW        = 4,
  parameter int WAIT_LIMIT = 15,
  parameter int CNTW       = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           ir_we,
  output logic           pc_we,
  output logic [1:0]     pc_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [2:0]     alu_op,
  output logic           reg_we,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           illegal_op,
  output logic           mem_err
);

  state_e          state_q, state_d;
  logic [CNTW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]      imm_alu_op;
  logic            mem_wait;
  logic            timeout;
  logic            opcode_legal;

  multicycle_ctrl_imm_alu_op_dec #(.OPW(OPW)) u_imm_dec (
    .opcode (opcode),
    .alu_op (imm_alu_op)
  );

  assign mem_wait     = is_mem_wait(state_q);
  // mem_ready takes priority over an expiring wait counter.
  assign timeout      = mem_wait && !mem_ready && (wait_cnt_q == CNTW'(WAIT_LIMIT));
  assign opcode_legal = (opcode <= OPW'(OP_J));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    if (mem_wait && !mem_ready && !timeout) begin
      wait_cnt_d = wait_cnt_q + CNTW'(1);
    end
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (opcode == OPW'(OP_RTYPE)) begin
          state_d = ST_EXEC_R;
        end else if (opcode >= OPW'(OP_ADDI) && opcode <= OPW'(OP_SLTI)) begin
          state_d = ST_EXEC_I;
        end else if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW)) begin
          state_d = ST_MEM_ADDR;
        end else if (opcode == OPW'(OP_BEQ)) begin
          state_d = ST_BRANCH;
        end else if (opcode == OPW'(OP_J)) begin
          state_d = ST_JUMP;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC_R:   state_d = ST_R_WB;
      ST_R_WB:     state_d = ST_FETCH;
      ST_EXEC_I:   state_d = ST_I_WB;
      ST_I_WB:     state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (opcode == OPW'(OP_LW)) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (mem_ready)    state_d = ST_MEM_WB;
        else if (timeout) state_d = ST_FETCH;
      end
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   if (mem_ready || timeout) state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALU_FUNC;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        alu_op     = ALU_ADD;
        illegal_op = !opcode_legal;
      end
      ST_EXEC_R: alu_src_a = 1'b1;
      ST_R_WB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_alu_op;
      end
      ST_I_WB: reg_we = 1'b1;
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      ST_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we     = zero;
      end
      ST_JUMP: begin
        pc_src = PC_JUMP;
        pc_we  = 1'b1;
      end
      default: ;
    endcase
    mem_err = timeout;
  end

endmodule
